// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU with registered result/flags and iterative shift-add multiplier
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int MUL_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   a_sh, b_sh, acc, acc_next;
    logic [SHAMT_W-1:0] count;
    logic               accept, is_mul, mul_last;

    logic [WIDTH:0]     sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res;
    logic               res_carry, res_ovf, res_illegal;

    assign in_ready = reset && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (in_op == OP_MUL) && (MUL_EN != 0);
    assign busy     = (state == ST_MUL);
    assign mul_last = (state == ST_MUL) && (count == LAST_CNT);
    assign acc_next = acc + (b_sh[0] ? a_sh : '0);

    assign sum   = {1'b0, in_a} + {1'b0, in_b};
    assign diff  = {1'b0, in_a} - {1'b0, in_b};
    assign shamt = in_b[SHAMT_W-1:0];

    // Single-cycle datapath; MUL result comes from the iterative path instead.
    always_comb begin
        res         = '0;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        case (in_op)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
                res_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = ~diff[WIDTH];
                res_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  res = in_a & in_b;
            OP_OR:   res = in_a | in_b;
            OP_XOR:  res = in_a ^ in_b;
            OP_NOR:  res = ~(in_a | in_b);
            OP_SLL:  res = in_a << shamt;
            OP_SRL:  res = in_a >> shamt;
            OP_SRA:  res = WIDTH'($signed(in_a) >>> shamt);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_MUL:  res_illegal = (MUL_EN == 0);
            default: res_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                a_sh  <= in_a;
                b_sh  <= in_b;
                acc   <= '0;
                count <= '0;
            end else if (state == ST_MUL) begin
                acc   <= acc_next;
                a_sh  <= a_sh << 1;
                b_sh  <= b_sh >> 1;
                count <= count + SHAMT_W'(1);
            end

            // A MUL accept needs an empty or draining output, so it falls to the clear branch.
            if (accept && !is_mul) begin
                out_valid   <= 1'b1;
                out_result  <= res;
                out_zero    <= (res == '0);
                out_carry   <= res_carry;
                out_ovf     <= res_ovf;
                out_illegal <= res_illegal;
            end else if (mul_last) begin
                out_valid   <= 1'b1;
                out_result  <= acc_next;
                out_zero    <= (acc_next == '0);
                out_carry   <= 1'b0;
                out_ovf     <= 1'b0;
                out_illegal <= 1'b0;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor to the single-cycle 7-op ALU. It registers its operands on a valid/ready input handshake and computes single-cycle logic, arithmetic, compare and shift ops with a registered result and flags. It also adds an iterative shift-add multiplier as a multi-cycle op. The result is held in an output register under a valid/ready output handshake, so the block sits between an operand-issue stage and a writeback stage with backpressure in both directions.

Parameters:
WIDTH, 32, datapath width in bits (>=4, power of two).
SHAMT_W, $clog2(WIDTH), number of low bits of B used as the shift amount.
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block accepts operands this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  4  opcode
out_valid  out  1  result register holds an undelivered result
out_ready  in  1  consumer takes the result this cycle
out_result  out  WIDTH  result
out_zero  out  1  out_result == 0
out_carry  out  1  ADD carry-out; SUB no-borrow (A >= B unsigned); else 0
out_ovf  out  1  signed overflow for ADD/SUB; else 0
out_illegal  out  1  opcode not implemented
busy  out  1  multiplier FSM not in IDLE

Behaviour:
- Opcodes:
  - 0000 ADD; 0010 SUB; 0100 AND; 0101 OR; 0110 XOR; 0111 NOR = ~(A|B).
  - 1010 SLT signed; 1011 SLTU unsigned. Both return 1 or 0, zero-extended.
  - 1000 SLL; 1001 SRL; 1100 SRA. Shift amount is B[SHAMT_W-1:0].
  - 1110 MUL: low WIDTH bits of A*B (sign-agnostic).
  - Any other opcode, or MUL when MUL_EN=0: result 0, out_illegal=1, all other flags 0, out_zero=1.
- Reset (reset low, asynchronous): out_valid=0, out_result=0, all flags 0, busy=0, FSM=IDLE, multiplier counter/accumulator cleared. A MUL in flight is discarded, with no output. in_ready is 0 while reset is low.
- Accept condition: in_valid & in_ready at a rising edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready). Combinational; it never depends on in_valid.
- FSM states:
  - IDLE: non-MUL accept loads the output register at that edge, so out_valid=1 the next cycle (latency 1). MUL accept latches A and B, clears the accumulator, sets count=0 and moves to MUL.
  - MUL: each cycle, if B_shift[0] then acc += A_shift; then A_shift <<= 1, B_shift >>= 1, count++. When count reaches WIDTH-1, that edge loads out_result=acc(final), sets the flags and out_valid=1, and returns to IDLE.
  - MUL latency: out_valid rises exactly WIDTH cycles after the accepting edge.
  - busy=1 and in_ready=0 throughout MUL.
- Output register: holds its value and flags while out_valid & !out_ready. Delivery occurs at an edge with out_valid & out_ready.
  - Delivery with no new load clears out_valid.
  - Delivery and a non-MUL accept at the same edge leaves out_valid=1 with the new result (full throughput: 1 op/cycle).
  - Delivery and a MUL accept at the same edge clears out_valid.
- Flags are computed from the same operands as the result and registered with it. out_zero reflects the registered result for every op.
- ADD/SUB use WIDTH+1-bit arithmetic, all wrap-around modulo 2^WIDTH.
  - Overflow on ADD: A and B have the same sign and the result sign differs.
  - Overflow on SUB: A and B have different signs and the result sign differs from A.
- out_result/flags are undefined-free: they hold their last value when out_valid=0.

Test Plan:
- Reset low mid-MUL (WIDTH=32, A=7, B=9, reset after 10 cycles) -> out_valid=0, busy=0, FSM IDLE immediately; no result ever appears; after reset release in_ready=1.
- Back-to-back ADD 0xFFFFFFFF+1, SUB 5-7, SLT 0x80000000<1, with out_ready held 1 -> results on consecutive cycles:
  - 0 with zero=1, carry=1, ovf=0;
  - 0xFFFFFFFE with carry=0;
  - 1.
- Overflow and logic ops:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
  - NOR 0,0 -> 0xFFFFFFFF, zero=0.
  - SRA 0x80000000 by B=0x24 (uses 4) -> 0xF8000000.
- MUL 0x0000FFFF * 0x00010001 -> out_valid exactly 32 cycles after accept, result 0xFFFFFFFF. busy=1 and in_ready=0 during those cycles. in_valid held during MUL is not accepted.
- Backpressure: out_ready=0 for 5 cycles after an XOR result -> out_result and flags stable and in_ready=0. Raising out_ready with a pending AND accepts it at the same edge; the AND result follows on the next cycle.
- Opcode 1111, and MUL built with MUL_EN=0 -> result 0, out_illegal=1, out_zero=1, latency 1 cycle.
